// File: rtl/decoder_r_stage.sv
// R-type decode stage for RV64F: classifies OP, OP-32 and OP-FP words.
// Ports: in_* (valid/ready/insn/tag), out_* (decoded entry), flush, illegal_count.
module decoder_r_stage #(
  parameter int XLEN     = 64,
  parameter int ENABLE_M = 1,
  parameter int ENABLE_F = 1,
  parameter int TAG_W    = 64,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_insn,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [TAG_W-1:0] out_tag,
  output logic [4:0]       out_rd,
  output logic [4:0]       out_rs1,
  output logic [4:0]       out_rs2,
  output logic [2:0]       out_funct3,
  output logic             out_sub_sra,
  output logic             out_is_word,
  output logic             out_is_mul,
  output logic             out_is_fp,
  output logic [4:0]       out_fp_funct5,
  output logic             out_illegal,
  output logic [CNT_W-1:0] illegal_count
);

  localparam logic [6:0] OP_OP   = 7'b0110011;
  localparam logic [6:0] OP_OP32 = 7'b0111011;
  localparam logic [6:0] OP_FP   = 7'b1010011;
  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;
  localparam logic [6:0] F7_MUL  = 7'b0000001;

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [4:0]       rd;
    logic [4:0]       rs1;
    logic [4:0]       rs2;
    logic [2:0]       funct3;
    logic             sub_sra;
    logic             is_word;
    logic             is_mul;
    logic             is_fp;
    logic [4:0]       fp_funct5;
    logic             illegal;
  } ent_t;

  ent_t       dec;
  ent_t       main_q;
  ent_t       skid_q;
  logic       main_v;
  logic       skid_v;
  logic       accept;
  logic       legal;
  logic       arith;
  logic       word;
  logic       mul;
  logic       fp;
  logic [6:0] op;
  logic [6:0] f7;
  logic [2:0] f3;

  assign op = in_insn[6:0];
  assign f7 = in_insn[31:25];
  assign f3 = in_insn[14:12];

  always_comb begin
    legal = 1'b0;
    arith = 1'b0;
    word  = 1'b0;
    mul   = 1'b0;
    fp    = 1'b0;
    case (op)
      OP_OP: begin
        arith = 1'b1;
        unique case (1'b1)
          (f7 == F7_BASE): legal = 1'b1;
          (f7 == F7_ALT):
            legal = (f3 == 3'b000) || (f3 == 3'b101);
          (f7 == F7_MUL): begin
            mul   = 1'b1;
            legal = (ENABLE_M != 0);
          end
          default: legal = 1'b0;
        endcase
      end
      OP_OP32: begin
        arith = 1'b1;
        word  = 1'b1;
        unique case (1'b1)
          (f7 == F7_BASE):
            legal = (f3 == 3'b000) || (f3 == 3'b001)
                 || (f3 == 3'b101);
          (f7 == F7_ALT):
            legal = (f3 == 3'b000) || (f3 == 3'b101);
          (f7 == F7_MUL): begin
            mul   = 1'b1;
            legal = (ENABLE_M != 0)
                 && (f3 != 3'b001) && (f3 != 3'b010)
                 && (f3 != 3'b011);
          end
          default: legal = 1'b0;
        endcase
        if (XLEN != 64) legal = 1'b0;
      end
      OP_FP: begin
        fp    = 1'b1;
        legal = (ENABLE_F != 0) && (in_insn[26:25] == 2'b00);
      end
      default: legal = 1'b0;
    endcase
  end

  always_comb begin
    dec           = '0;
    dec.tag       = in_tag;
    dec.rd        = in_insn[11:7];
    dec.rs1       = in_insn[19:15];
    dec.rs2       = in_insn[24:20];
    dec.funct3    = f3;
    dec.fp_funct5 = in_insn[31:27];
    dec.illegal   = ~legal;
    dec.is_word   = legal & word;
    dec.is_mul    = legal & mul;
    dec.is_fp     = legal & fp;
    dec.sub_sra   = legal & arith & ~mul
                  & ((~f3[2] & f3[1]) | in_insn[30]);
  end

  // in_ready comes straight from the skid flop, so the
  // upstream never sees a path from out_ready.
  assign in_ready = ~skid_v;
  assign accept   = in_valid & ~skid_v;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_q <= '0;
      skid_q <= '0;
      main_v <= 1'b0;
      skid_v <= 1'b0;
    end else if (flush) begin
      main_v <= 1'b0;
      skid_v <= 1'b0;
    end else if (!main_v || out_ready) begin
      if (skid_v) begin
        main_q <= skid_q;
        main_v <= 1'b1;
        skid_v <= 1'b0;
      end else begin
        main_v <= accept;
        if (accept) main_q <= dec;
      end
    end else if (accept) begin
      skid_q <= dec;
      skid_v <= 1'b1;
    end
  end

  // Delivered handshakes count even in a flush cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      illegal_count <= '0;
    end else if (main_v && out_ready && main_q.illegal
                 && !(&illegal_count)) begin
      illegal_count <= illegal_count + 1'b1;
    end
  end

  assign out_valid     = main_v;
  assign out_tag       = main_q.tag;
  assign out_rd        = main_q.rd;
  assign out_rs1       = main_q.rs1;
  assign out_rs2       = main_q.rs2;
  assign out_funct3    = main_q.funct3;
  assign out_sub_sra   = main_q.sub_sra;
  assign out_is_word   = main_q.is_word;
  assign out_is_mul    = main_q.is_mul;
  assign out_is_fp     = main_q.is_fp;
  assign out_fp_funct5 = main_q.fp_funct5;
  assign out_illegal   = main_q.illegal;

endmodule

// File: tb/tb_decoder_r_stage.sv
// Bench for decoder_r_stage: full config and RV32/no-M/CNT_W=2 config
// share stimulus; a queue of expected entries is checked at the output.
module tb_decoder_r_stage;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic [31:0] in_insn;
  logic [63:0] in_tag;
  logic        out_ready;

  logic        in_ready, out_valid;
  logic [63:0] out_tag;
  logic [4:0]  out_rd, out_rs1, out_rs2, out_fp_funct5;
  logic [2:0]  out_funct3;
  logic        out_sub_sra, out_is_word, out_is_mul, out_is_fp;
  logic        out_illegal;
  logic [15:0] illegal_count;

  logic        b_in_ready, b_out_valid;
  logic [63:0] b_tag;
  logic [4:0]  b_rd, b_rs1, b_rs2, b_fp_funct5;
  logic [2:0]  b_funct3;
  logic        b_sub_sra, b_is_word, b_is_mul, b_is_fp, b_illegal;
  logic [1:0]  b_count;

  decoder_r_stage u_dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_insn(in_insn), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_tag(out_tag), .out_rd(out_rd),
    .out_rs1(out_rs1), .out_rs2(out_rs2),
    .out_funct3(out_funct3), .out_sub_sra(out_sub_sra),
    .out_is_word(out_is_word), .out_is_mul(out_is_mul),
    .out_is_fp(out_is_fp), .out_fp_funct5(out_fp_funct5),
    .out_illegal(out_illegal), .illegal_count(illegal_count)
  );

  decoder_r_stage #(
    .XLEN(32), .ENABLE_M(0), .ENABLE_F(1),
    .TAG_W(64), .CNT_W(2)
  ) u_dut_b (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(b_in_ready),
    .in_insn(in_insn), .in_tag(in_tag),
    .out_valid(b_out_valid), .out_ready(out_ready),
    .out_tag(b_tag), .out_rd(b_rd),
    .out_rs1(b_rs1), .out_rs2(b_rs2),
    .out_funct3(b_funct3), .out_sub_sra(b_sub_sra),
    .out_is_word(b_is_word), .out_is_mul(b_is_mul),
    .out_is_fp(b_is_fp), .out_fp_funct5(b_fp_funct5),
    .out_illegal(b_illegal), .illegal_count(b_count)
  );

  typedef struct {
    logic [63:0] tag;
    logic [31:0] insn;
    logic [3:0]  fl;
    logic        ill;
    logic        ill_b;
  } exp_t;

  // {insn, {sub_sra,word,mul,fp}, illegal(full), illegal(rv32 no-M)}
  logic [37:0] vtab [16] = '{
    {32'h002081B3, 4'b0000, 1'b0, 1'b0},
    {32'h407302B3, 4'b1000, 1'b0, 1'b0},
    {32'h003120B3, 4'b1000, 1'b0, 1'b0},
    {32'h003100BB, 4'b0100, 1'b0, 1'b1},
    {32'h023100B3, 4'b0010, 1'b0, 1'b1},
    {32'hFE2080B3, 4'b0000, 1'b1, 1'b1},
    {32'h00208053, 4'b0001, 1'b0, 1'b0},
    {32'h02208053, 4'b0000, 1'b1, 1'b1},
    {32'h4020D1B3, 4'b1000, 1'b0, 1'b0},
    {32'h402091B3, 4'b0000, 1'b1, 1'b1},
    {32'h403100BB, 4'b1100, 1'b0, 1'b1},
    {32'h023110BB, 4'b0000, 1'b1, 1'b1},
    {32'h0020B1B3, 4'b1000, 1'b0, 1'b0},
    {32'h0020C1B3, 4'b0000, 1'b0, 1'b0},
    {32'h00000013, 4'b0000, 1'b1, 1'b1},
    {32'h0220C1B3, 4'b0010, 1'b0, 1'b1}
  };

  exp_t        q[$];
  exp_t        cur_e;
  exp_t        e;
  int          tests = 0;
  int          errors = 0;
  int          pops = 0;
  int          cyc = 0;
  int          mdl_a = 0;
  int          mdl_b = 0;
  logic [63:0] next_tag = 64'h1000;
  logic [91:0] ga, xa;
  logic [69:0] gb, xb;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc++;

  // Output checker and scoreboard push, away from the active edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid && out_ready) begin
        tests++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_output tag=%h", out_tag);
        end else begin
          e = q.pop_front();
          pops++;
          ga = {out_tag, out_rd, out_rs1, out_rs2, out_funct3,
                out_fp_funct5, out_sub_sra, out_is_word,
                out_is_mul, out_is_fp, out_illegal};
          xa = {e.tag, e.insn[11:7], e.insn[19:15],
                e.insn[24:20], e.insn[14:12], e.insn[31:27],
                e.fl, e.ill};
          gb = {b_out_valid, b_tag, b_sub_sra, b_is_word,
                b_is_mul, b_is_fp, b_illegal};
          xb = {1'b1, e.tag, (e.ill_b ? 4'b0000 : e.fl),
                e.ill_b};
          if (ga !== xa || gb !== xb) begin
            errors++;
            $display("FAIL decode insn=%h got=%h/%h want=%h/%h",
                     e.insn, ga, gb, xa, xb);
          end
          if (e.ill) mdl_a++;
          if (e.ill_b && mdl_b < 3) mdl_b++;
        end
      end
      if (flush) q.delete();
      else if (in_valid && in_ready) q.push_back(cur_e);
    end
  end

  task automatic present(input int i);
    logic [37:0] v;
    v           = vtab[i];
    in_valid    = 1'b1;
    in_insn     = v[37:6];
    in_tag      = next_tag;
    cur_e.tag   = next_tag;
    cur_e.insn  = v[37:6];
    cur_e.fl    = v[5:2];
    cur_e.ill   = v[1];
    cur_e.ill_b = v[0];
    next_tag    = next_tag + 64'd1;
  endtask

  task automatic send(input int i);
    int n;
    n = 0;
    present(i);
    while (!in_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) begin
      tests++;
      errors++;
      $display("FAIL send_timeout insn=%h", in_insn);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q.size() != 0 || out_valid) && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    tests++;
    if (q.size() != 0 || out_valid) begin
      errors++;
      $display("FAIL drain_timeout left=%0d want=0", q.size());
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    q.delete();
    mdl_a = 0;
    mdl_b = 0;
  endtask

  task automatic test_reset();
    flush = 1'b0; in_valid = 1'b0; in_insn = '0;
    in_tag = '0; out_ready = 1'b0;
    do_reset();
    #2;
    tests++;
    if ({out_valid, in_ready, b_out_valid, b_in_ready}
        !== 4'b0101) begin
      errors++;
      $display("FAIL reset_handshake got=%b want=0101",
               {out_valid, in_ready, b_out_valid, b_in_ready});
    end
    tests++;
    if ({out_tag, out_rd, out_rs1, out_rs2, out_funct3,
         out_fp_funct5, out_sub_sra, out_is_word, out_is_mul,
         out_is_fp, out_illegal} !== 92'd0) begin
      errors++;
      $display("FAIL reset_data got tag=%h rd=%0d want 0",
               out_tag, out_rd);
    end
    tests++;
    if (illegal_count !== 16'd0 || b_count !== 2'd0) begin
      errors++;
      $display("FAIL reset_count got=%0d/%0d want=0/0",
               illegal_count, b_count);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_latency();
    out_ready = 1'b1;
    send(0);
    tests++;
    if ({out_valid, out_rd, out_rs1, out_rs2, out_funct3,
         out_sub_sra, out_illegal}
        !== {1'b1, 5'd3, 5'd1, 5'd2, 3'd0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL add_latency got v=%b rd=%0d want v=1 rd=3",
               out_valid, out_rd);
    end
    drain();
  endtask

  task automatic test_decode_stream();
    int c0;
    out_ready = 1'b1;
    c0 = cyc;
    for (int i = 0; i < 16; i++) send(i);
    tests++;
    if (cyc - c0 != 16) begin
      errors++;
      $display("FAIL throughput cycles=%0d want=16", cyc - c0);
    end
    drain();
    tests++;
    if (illegal_count !== 16'(mdl_a) || b_count !== 2'(mdl_b)) begin
      errors++;
      $display("FAIL stream_count got=%0d/%0d want=%0d/%0d",
               illegal_count, b_count, mdl_a, mdl_b);
    end
  endtask

  task automatic test_back_to_back();
    int p0;
    logic [63:0] ta;
    logic [63:0] tb;
    p0 = pops;
    out_ready = 1'b0;
    ta = next_tag;
    present(1);
    @(posedge clk); #1;
    tb = next_tag;
    present(4);
    @(posedge clk); #1;
    present(10);
    tests++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL stall_ready got=%b want=0", in_ready);
    end
    @(posedge clk); #1;
    @(posedge clk); #1;
    tests++;
    if (out_valid !== 1'b1 || out_tag !== ta || in_ready !== 1'b0
        || out_rd !== 5'd5) begin
      errors++;
      $display("FAIL stall_hold got tag=%h rdy=%b want tag=%h rdy=0",
               out_tag, in_ready, ta);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    tests++;
    if (in_ready !== 1'b1 || out_tag !== tb) begin
      errors++;
      $display("FAIL release got rdy=%b tag=%h want rdy=1 tag=%h",
               in_ready, out_tag, tb);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    drain();
    tests++;
    if (pops - p0 != 3) begin
      errors++;
      $display("FAIL b2b_count got=%0d want=3", pops - p0);
    end
  endtask

  task automatic test_flush();
    int p0;
    out_ready = 1'b0;
    present(5);
    @(posedge clk); #1;
    present(0);
    @(posedge clk); #1;
    p0 = pops;
    present(1);
    flush = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    in_valid = 1'b0;
    tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1
        || pops - p0 != 1) begin
      errors++;
      $display("FAIL flush_full got v=%b rdy=%b pops=%0d want 0 1 1",
               out_valid, in_ready, pops - p0);
    end
    tests++;
    if (illegal_count !== 16'(mdl_a) || mdl_a == 0) begin
      errors++;
      $display("FAIL flush_count got=%0d want=%0d",
               illegal_count, mdl_a);
    end
    out_ready = 1'b0;
    present(2);
    @(posedge clk); #1;
    present(3);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    tests++;
    if (out_valid !== 1'b0 || b_out_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_drop got v=%b want=0", out_valid);
    end
    out_ready = 1'b1;
  endtask

  task automatic test_reset_mid_stall();
    out_ready = 1'b0;
    present(14);
    @(posedge clk); #1;
    present(0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    #2;
    do_reset();
    #1;
    tests++;
    if ({out_valid, in_ready, out_illegal, out_rd} !== 8'b0100_0000
        || out_tag !== 64'd0 || illegal_count !== 16'd0) begin
      errors++;
      $display("FAIL async_reset got v=%b rdy=%b tag=%h cnt=%0d",
               out_valid, in_ready, out_tag, illegal_count);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
  endtask

  task automatic test_saturate();
    out_ready = 1'b1;
    send(5);
    send(7);
    send(9);
    send(11);
    send(14);
    drain();
    tests++;
    if (b_count !== 2'd3 || illegal_count !== 16'd5) begin
      errors++;
      $display("FAIL saturate got=%0d/%0d want=5/3",
               illegal_count, b_count);
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_decode_stream();
    test_back_to_back();
    test_flush();
    test_reset_mid_stall();
    test_saturate();
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
